alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_op_decode.sv | 111 +++++++++++
 rtl/alu_issue_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes,
// RV32I opcode/funct constants and the issue record layout.
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int ALU_XLEN = 32;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 4'b1100;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 4'b1101;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 4'b1110;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 4'b1111;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Issue record at the default 32-bit datapath width
    typedef struct packed {
        logic [ALU_XLEN-1:0] SrcA;
        logic [ALU_XLEN-1:0] SrcB;
        logic [ALU_OP_W-1:0] Operation;
        logic [4:0]          rd;
        logic                illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operands and operation code.
// Optional feature: define ALU_ISSUE_SHIFT_EN to decode SLLI/SRLI/SRAI;
// without it those encodings are reported as illegal.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    output logic [DATA_WIDTH-1:0]    srca,
    output logic [DATA_WIDTH-1:0]    srcb,
    output logic [OPCODE_LENGTH-1:0] operation,
    output logic [4:0]               rd,
    output logic                     illegal
);

    logic [6:0]                   opcode;
    logic [2:0]                   funct3;
    logic [6:0]                   funct7;
    logic signed [11:0]           imm_s;
    logic signed [DATA_WIDTH-1:0] imm_ext;
    logic [ALU_OP_W-1:0]          op;
    logic [DATA_WIDTH-1:0]        a;
    logic [DATA_WIDTH-1:0]        b;
    logic                         ill;
    // Register indices are resolved upstream; rs1 field is not needed here
    logic                         unused_rs1_idx;

    assign opcode         = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[31:25];
    assign imm_s          = instr[31:20];
    assign imm_ext        = DATA_WIDTH'(imm_s);
    assign rd             = instr[11:7];
    assign unused_rs1_idx = ^instr[19:15];

`ifdef ALU_ISSUE_SHIFT_EN
    logic [DATA_WIDTH-1:0] shamt_ext;
    assign shamt_ext = DATA_WIDTH'(instr[24:20]);
`endif

    // p0: decode opcode/funct fields into operation and operand selection
    always_comb begin
        op  = OP_AND;
        a   = rs1_data;
        b   = rs2_data;
        ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
                    op = OP_SUB;
                end else if (funct7 != F7_BASE) begin
                    ill = 1'b1;
                end else begin
                    case (funct3)
                        F3_ADD_SUB: op  = OP_ADD;
                        F3_AND:     op  = OP_AND;
                        F3_OR:      op  = OP_OR;
                        F3_XOR:     op  = OP_XOR;
                        F3_SLT:     op  = OP_SLT;
                        default:    ill = 1'b1;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                b = imm_ext;
                case (funct3)
                    F3_ADD_SUB: op = OP_ADD;
                    F3_AND:     op = OP_AND;
                    F3_OR:      op = OP_OR;
                    F3_XOR:     op = OP_XOR;
                    F3_SLT:     op = OP_SLT;
`ifdef ALU_ISSUE_SHIFT_EN
                    F3_SLL: begin
                        b = shamt_ext;
                        if (funct7 == F7_BASE) op = OP_SLL;
                        else                   ill = 1'b1;
                    end
                    F3_SR: begin
                        b = shamt_ext;
                        if (funct7 == F7_BASE)     op = OP_SRL;
                        else if (funct7 == F7_ALT) op = OP_SRA;
                        else                       ill = 1'b1;
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) op  = OP_EQ;
                else                  ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Undecodable instructions travel on with neutral operands
        if (ill) begin
            op = OP_AND;
            a  = '0;
            b  = '0;
        end
    end

    assign srca      = a;
    assign srcb      = b;
    assign operation = OPCODE_LENGTH'(op);
    assign illegal   = ill;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction and buffers the result in a
// main output register backed by one skid register (valid/ready on both
// sides, registered in_ready). Counts accepted illegal instructions.
// Optional feature: ALU_ISSUE_SHIFT_EN enables immediate shift decode.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [4:0]               rd,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    srca;
        logic [DATA_WIDTH-1:0]    srcb;
        logic [OPCODE_LENGTH-1:0] op;
        logic [4:0]               rd;
        logic                     ill;
    } entry_t;

    entry_t dec_p0;
    entry_t main_p1;
    entry_t skid_p1;
    state_t state;
    logic   vld_p1;
    logic   rdy_p1;
    logic   in_xfer;
    logic   out_xfer;

    // p0: combinational decode of the incoming instruction
    alu_op_decode #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_decode (
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .srca      (dec_p0.srca),
        .srcb      (dec_p0.srcb),
        .operation (dec_p0.op),
        .rd        (dec_p0.rd),
        .illegal   (dec_p0.ill)
    );

    assign in_xfer  = in_valid & rdy_p1;
    assign out_xfer = vld_p1 & out_ready;

    // p1: main/skid buffering FSM with registered handshakes and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            vld_p1      <= 1'b0;
            rdy_p1      <= 1'b1;
            illegal_cnt <= '0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else begin
            if (in_xfer && dec_p0.ill && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
            end
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_p1 <= dec_p0;
                        vld_p1  <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_p1 <= dec_p0;
                        rdy_p1  <= 1'b0;
                        state   <= FULL;
                    end else if (!in_xfer && out_xfer) begin
                        vld_p1  <= 1'b0;
                        state   <= EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_p1 <= dec_p0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (out_xfer) begin
                        main_p1 <= skid_p1;
                        rdy_p1  <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    vld_p1 <= 1'b0;
                    rdy_p1 <= 1'b1;
                    state  <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign SrcA      = main_p1.srca;
    assign SrcB      = main_p1.srcb;
    assign Operation = main_p1.op;
    assign rd        = main_p1.rd;
    assign illegal   = main_p1.ill;

endmodule
